// File: rtl/hbus_clk_gen_pkg.sv
// Shared constants and types for the HyperBus clock generator.
package hbus_clk_gen_pkg;

  localparam int unsigned HBUS_DIV_W_DEF = 4;
  localparam int unsigned HBUS_CNT_W_DEF = 16;
  localparam int unsigned HBUS_PH_W_DEF  = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LEAD = 2'd1,
    ST_HIGH = 2'd2,
    ST_LOW  = 2'd3
  } hbus_state_t;

  function automatic int unsigned max_w(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/hbus_clk_gen_half_timer.sv
// Loadable down-counter with zero flag; times both the lead delay and each half-period.
module hbus_half_timer #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt;

  // Load wins; otherwise count down and hold at zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/hbus_clk_gen.sv
// HyperBus ram_clk burst generator: programmable length, half-period and lead phase.
module hbus_clk_gen
  import hbus_clk_gen_pkg::*;
#(
  parameter int unsigned DIV_W = HBUS_DIV_W_DEF,
  parameter int unsigned CNT_W = HBUS_CNT_W_DEF,
  parameter int unsigned PH_W  = HBUS_PH_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] len,
  input  logic [DIV_W-1:0] half_div,
  input  logic [PH_W-1:0]  phase,
  input  logic             stop,
  output logic             ram_clk,
  output logic             rise_stb,
  output logic             fall_stb,
  output logic             busy,
  output logic             done
);

  localparam int unsigned TMR_W = max_w(DIV_W, PH_W);

  hbus_state_t      state;
  logic [CNT_W-1:0] per_cnt;
  logic [DIV_W-1:0] half_div_r;
  logic             stop_pend;
  logic             tmr_load;
  logic [TMR_W-1:0] tmr_val;
  logic             tmr_zero;
  logic             last_per;

  hbus_half_timer #(.W(TMR_W)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .zero     (tmr_zero)
  );

  // Burst ends at this LOW boundary if the count is exhausted or a stop is pending.
  assign last_per = (per_cnt == CNT_W'(1)) || stop_pend || stop;

  // Timer reload: on accepted start, then at every expiry while active. Reloading
  // on the expiry that returns to IDLE is harmless since the next start reloads.
  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = TMR_W'(half_div_r);
    if (state == ST_IDLE) begin
      if (start && (len != '0)) begin
        tmr_load = 1'b1;
        tmr_val  = (phase == '0) ? TMR_W'(half_div) : TMR_W'(phase - PH_W'(1));
      end
    end else if (tmr_zero) begin
      tmr_load = 1'b1;
    end
  end

  // Burst FSM with registered clock, strobes, busy and done.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      per_cnt    <= '0;
      half_div_r <= '0;
      stop_pend  <= 1'b0;
      ram_clk    <= 1'b0;
      rise_stb   <= 1'b0;
      fall_stb   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      rise_stb <= 1'b0;
      fall_stb <= 1'b0;
      done     <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            half_div_r <= half_div;
            per_cnt    <= len;
            stop_pend  <= 1'b0;
            if (len == '0) begin
              done <= 1'b1;
            end else if (phase == '0) begin
              state    <= ST_HIGH;
              ram_clk  <= 1'b1;
              rise_stb <= 1'b1;
              busy     <= 1'b1;
            end else begin
              state <= ST_LEAD;
              busy  <= 1'b1;
            end
          end
        end
        ST_LEAD: begin
          if (stop) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else if (tmr_zero) begin
            state    <= ST_HIGH;
            ram_clk  <= 1'b1;
            rise_stb <= 1'b1;
          end
        end
        ST_HIGH: begin
          if (stop) stop_pend <= 1'b1;
          if (tmr_zero) begin
            state    <= ST_LOW;
            ram_clk  <= 1'b0;
            fall_stb <= 1'b1;
          end
        end
        ST_LOW: begin
          if (stop) stop_pend <= 1'b1;
          if (tmr_zero) begin
            if (last_per) begin
              state     <= ST_IDLE;
              per_cnt   <= '0;
              stop_pend <= 1'b0;
              busy      <= 1'b0;
              done      <= 1'b1;
            end else begin
              state    <= ST_HIGH;
              per_cnt  <= per_cnt - CNT_W'(1);
              ram_clk  <= 1'b1;
              rise_stb <= 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hbus_clk_gen.sv
// Directed bench for hbus_clk_gen; outputs sampled on negedge as {ram_clk,rise,fall,busy,done}.
module tb_hbus_clk_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [15:0] len = '0;
  logic [3:0]  half_div = '0;
  logic [2:0]  phase = '0;
  logic        ram_clk, rise_stb, fall_stb, busy, done;
  logic [4:0]  obs;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign obs = {ram_clk, rise_stb, fall_stb, busy, done};

  hbus_clk_gen #(.DIV_W(4), .CNT_W(16), .PH_W(3)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .len      (len),
    .half_div (half_div),
    .phase    (phase),
    .stop     (stop),
    .ram_clk  (ram_clk),
    .rise_stb (rise_stb),
    .fall_stb (fall_stb),
    .busy     (busy),
    .done     (done)
  );

  // Reference waveform for cycle k after the accepting edge (k=1 is the first cycle after it).
  function automatic logic [4:0] exp_vec(input int k, input int l, input int h, input int p);
    int per, fin, j;
    per = 2 * (h + 1);
    fin = p + per * l;
    if (k >= 1 && k <= p) return 5'b00010;
    if (k > p && k <= fin) begin
      j = (k - p - 1) % per;
      return {(j <= h), (j == 0), (j == h + 1), 1'b1, 1'b0};
    end
    if (k >= 1 && k == fin + 1) return 5'b00001;
    return 5'b00000;
  endfunction

  task automatic do_start(input logic [15:0] l, input logic [3:0] h, input logic [2:0] p);
    @(negedge clk);
    len = l; half_div = h; phase = p; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; len = 16'd4;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (obs !== 5'b00000) begin
        errors++; $display("FAIL reset_hold cyc=%0d got %b exp %b", i, obs, 5'b00000);
      end
    end
    start = 1'b0; rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (obs !== 5'b00000) begin
        errors++; $display("FAIL reset_release cyc=%0d got %b exp %b", i, obs, 5'b00000);
      end
    end
  endtask

  task automatic test_basic();
    do_start(16'd4, 4'd0, 3'd0);
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      checks++;
      if (obs !== exp_vec(k, 4, 0, 0)) begin
        errors++; $display("FAIL basic k=%0d got %b exp %b", k, obs, exp_vec(k, 4, 0, 0));
      end
    end
  endtask

  task automatic test_phase();
    do_start(16'd2, 4'd2, 3'd3);
    for (int k = 1; k <= 18; k++) begin
      @(negedge clk);
      checks++;
      if (obs !== exp_vec(k, 2, 2, 3)) begin
        errors++; $display("FAIL phase k=%0d got %b exp %b", k, obs, exp_vec(k, 2, 2, 3));
      end
    end
  endtask

  task automatic test_stop();
    logic [4:0] e;
    // stop in second HIGH: two full periods of 4 cycles, done at k=9
    do_start(16'd100, 4'd1, 3'd0);
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      checks++;
      if (obs !== exp_vec(k, 2, 1, 0)) begin
        errors++; $display("FAIL stop_high k=%0d got %b exp %b", k, obs, exp_vec(k, 2, 1, 0));
      end
      stop = (k == 5);
    end
    stop = 1'b0;
    idle(2);
    // stop during LEAD: done next cycle, never a ram_clk edge
    do_start(16'd3, 4'd0, 3'd5);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      e = (k <= 2) ? 5'b00010 : (k == 3) ? 5'b00001 : 5'b00000;
      checks++;
      if (obs !== e) begin
        errors++; $display("FAIL stop_lead k=%0d got %b exp %b", k, obs, e);
      end
      stop = (k == 2);
    end
    stop = 1'b0;
    idle(2);
    // maximum length, stopped during first HIGH: one period then done
    do_start(16'hFFFF, 4'd0, 3'd0);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      checks++;
      if (obs !== exp_vec(k, 1, 0, 0)) begin
        errors++; $display("FAIL stop_maxlen k=%0d got %b exp %b", k, obs, exp_vec(k, 1, 0, 0));
      end
      stop = (k == 1);
    end
    stop = 1'b0;
    idle(2);
  endtask

  task automatic test_len_zero();
    logic [4:0] e;
    do_start(16'd0, 4'd3, 3'd4);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      e = (k == 1) ? 5'b00001 : 5'b00000;
      checks++;
      if (obs !== e) begin
        errors++; $display("FAIL len_zero k=%0d got %b exp %b", k, obs, e);
      end
    end
  endtask

  task automatic test_start_busy();
    do_start(16'd3, 4'd0, 3'd0);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      checks++;
      if (obs !== exp_vec(k, 3, 0, 0)) begin
        errors++; $display("FAIL start_busy k=%0d got %b exp %b", k, obs, exp_vec(k, 3, 0, 0));
      end
      if (k == 3) begin
        start = 1'b1; len = 16'd1; half_div = 4'd5; phase = 3'd2;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [4:0] e;
    do_start(16'd1, 4'd0, 3'd0);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      e = (k <= 3) ? exp_vec(k, 1, 0, 0) : exp_vec(k - 3, 2, 0, 0);
      checks++;
      if (obs !== e) begin
        errors++; $display("FAIL back_to_back k=%0d got %b exp %b", k, obs, e);
      end
      if (k == 3) begin
        start = 1'b1; len = 16'd2; half_div = 4'd0; phase = 3'd0;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
  endtask

  task automatic test_mid_reset();
    logic [4:0] e;
    do_start(16'd8, 4'd2, 3'd0);
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      e = (k <= 2) ? exp_vec(k, 8, 2, 0) : 5'b00000;
      checks++;
      if (obs !== e) begin
        errors++; $display("FAIL mid_reset k=%0d got %b exp %b", k, obs, e);
      end
      rst = (k == 2);
    end
    rst = 1'b0;
    do_start(16'd2, 4'd1, 3'd2);
    for (int k = 1; k <= 13; k++) begin
      @(negedge clk);
      checks++;
      if (obs !== exp_vec(k, 2, 1, 2)) begin
        errors++; $display("FAIL post_reset k=%0d got %b exp %b", k, obs, exp_vec(k, 2, 1, 2));
      end
    end
  endtask

  task automatic test_sweep();
    int l, h, p, fin, bad;
    logic [4:0] e, first_obs, first_exp;
    int first_k;
    for (int b = 0; b < 1000; b++) begin
      l = $urandom_range(4, 1);
      h = $urandom_range(3, 0);
      p = $urandom_range(3, 0);
      fin = p + 2 * (h + 1) * l;
      bad = 0; first_k = 0; first_obs = '0; first_exp = '0;
      do_start(16'(l), 4'(h), 3'(p));
      for (int k = 1; k <= fin + 1; k++) begin
        @(negedge clk);
        e = exp_vec(k, l, h, p);
        if (obs !== e) begin
          if (bad == 0) begin
            first_k = k; first_obs = obs; first_exp = e;
          end
          bad++;
        end
      end
      checks++;
      if (bad != 0) begin
        errors++;
        $display("FAIL sweep b=%0d len=%0d hd=%0d ph=%0d k=%0d got %b exp %b", b, l, h, p,
                 first_k, first_obs, first_exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    idle(2);
    test_phase();
    idle(2);
    test_stop();
    test_len_zero();
    idle(1);
    test_start_busy();
    idle(2);
    test_back_to_back();
    idle(2);
    test_mid_reset();
    idle(2);
    test_sweep();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
